// File: rtl/xf100_exu_wbck.sv
// Writeback arbiter merging the ALU and LSU writeback channels onto the single
// register-file write port, with a 2-entry ALU buffer and a starvation guard.
`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif
`ifndef XF100_RFIDX_WIDTH
`define XF100_RFIDX_WIDTH 5
`endif

module xf100_exu_wbck #(
  parameter int XLEN       = `XF100_XLEN,
  parameter int RFIDX_W    = `XF100_RFIDX_WIDTH,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_valid,
  output logic               alu_wbck_ready,
  input  logic               alu_wbck_en,
  input  logic [XLEN-1:0]    alu_wbck_data,
  input  logic [RFIDX_W-1:0] alu_wbck_rdidx,
  input  logic               lsu_wbck_valid,
  output logic               lsu_wbck_ready,
  input  logic [XLEN-1:0]    lsu_wbck_data,
  input  logic [RFIDX_W-1:0] lsu_wbck_rdidx,
  output logic               rf_wen,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [RFIDX_W-1:0] rf_wrdidx
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  logic [XLEN-1:0]    fifo_data [2];
  logic [RFIDX_W-1:0] fifo_idx  [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic [1:0]         starve_cnt;

  logic               fifo_nempty;
  logic               live_keep;
  logic               alu_cand;
  logic [XLEN-1:0]    cand_data;
  logic [RFIDX_W-1:0] cand_idx;
  logic               alu_hs;
  logic               lsu_hs;
  logic               lsu_win;
  logic               alu_win;
  logic               enq;
  logic               deq;

  assign fifo_nempty = (count != 2'd0);
  assign live_keep   = alu_wbck_valid && alu_wbck_en && (alu_wbck_rdidx != '0);
  assign alu_cand    = fifo_nempty || live_keep;
  assign cand_data   = fifo_nempty ? fifo_data[rd_ptr] : alu_wbck_data;
  assign cand_idx    = fifo_nempty ? fifo_idx[rd_ptr]  : alu_wbck_rdidx;

  // Readiness is forced high while in reset so the ports reflect the reset state.
  assign alu_wbck_ready = rst || (count != 2'd2);
  assign lsu_wbck_ready = rst || !((starve_cnt == STARVE_LIM) && alu_cand);

  assign alu_hs  = alu_wbck_valid && alu_wbck_ready;
  assign lsu_hs  = lsu_wbck_valid && lsu_wbck_ready;
  // An rd=0 load is consumed without a write, leaving the port to the ALU.
  assign lsu_win = lsu_hs && (lsu_wbck_rdidx != '0);
  assign alu_win = !lsu_win && alu_cand;
  assign enq     = alu_hs && live_keep && (fifo_nempty || !alu_win);
  assign deq     = fifo_nempty && alu_win;

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_data[wr_ptr] <= alu_wbck_data;
      fifo_idx[wr_ptr]  <= alu_wbck_rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (alu_cand && lsu_win) begin
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 2'd1;
      end else begin
        starve_cnt <= 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen    <= 1'b0;
      rf_wdata  <= '0;
      rf_wrdidx <= '0;
    end else begin
      rf_wen <= lsu_win || alu_win;
      if (lsu_win) begin
        rf_wdata  <= lsu_wbck_data;
        rf_wrdidx <= lsu_wbck_rdidx;
      end else if (alu_win) begin
        rf_wdata  <= cand_data;
        rf_wrdidx <= cand_idx;
      end
    end
  end

endmodule

// File: tb/tb_xf100_exu_wbck.sv
// Directed bench for xf100_exu_wbck: a queue-based writeback model checked every
// cycle, plus literal expectations for the key arbitration scenarios.
module tb_xf100_exu_wbck;

  logic        clk;
  logic        rst;
  logic        alu_wbck_valid;
  logic        alu_wbck_ready;
  logic        alu_wbck_en;
  logic [31:0] alu_wbck_data;
  logic [4:0]  alu_wbck_rdidx;
  logic        lsu_wbck_valid;
  logic        lsu_wbck_ready;
  logic [31:0] lsu_wbck_data;
  logic [4:0]  lsu_wbck_rdidx;
  logic        rf_wen;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_wrdidx;

  int total = 0;
  int bad   = 0;

  xf100_exu_wbck dut (
    .clk            (clk),
    .rst            (rst),
    .alu_wbck_valid (alu_wbck_valid),
    .alu_wbck_ready (alu_wbck_ready),
    .alu_wbck_en    (alu_wbck_en),
    .alu_wbck_data  (alu_wbck_data),
    .alu_wbck_rdidx (alu_wbck_rdidx),
    .lsu_wbck_valid (lsu_wbck_valid),
    .lsu_wbck_ready (lsu_wbck_ready),
    .lsu_wbck_data  (lsu_wbck_data),
    .lsu_wbck_rdidx (lsu_wbck_rdidx),
    .rf_wen         (rf_wen),
    .rf_wdata       (rf_wdata),
    .rf_wrdidx      (rf_wrdidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending ALU results in arrival order, and the loss streak.
  logic [36:0] mq[$];
  int          m_starve = 0;
  logic        m_wen    = 1'b0;
  logic [31:0] m_wdata  = 32'h0;
  logic [4:0]  m_widx   = 5'h0;
  bit          model_ok = 1'b0;

  function automatic bit live_keeps();
    return alu_wbck_valid && alu_wbck_en && (alu_wbck_rdidx != 5'd0);
  endfunction

  function automatic bit cand_now();
    return (mq.size() > 0) || live_keeps();
  endfunction

  function automatic bit exp_alu_ready();
    return rst || (mq.size() != 2);
  endfunction

  function automatic bit exp_lsu_ready();
    return rst || !((m_starve == 3) && cand_now());
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_starve = 0;
        m_wen    = 1'b0;
        m_wdata  = 32'h0;
        m_widx   = 5'h0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        bit alu_take, lsu_take, lsu_writes, cand;
        logic [36:0] head;
        alu_take   = alu_wbck_valid && exp_alu_ready() && live_keeps();
        lsu_take   = lsu_wbck_valid && exp_lsu_ready();
        lsu_writes = lsu_take && (lsu_wbck_rdidx != 5'd0);
        cand       = cand_now();
        if (lsu_writes) begin
          m_wen   = 1'b1;
          m_wdata = lsu_wbck_data;
          m_widx  = lsu_wbck_rdidx;
          m_starve = cand ? ((m_starve < 3) ? m_starve + 1 : 3) : 0;
          if (alu_take) mq.push_back({alu_wbck_data, alu_wbck_rdidx});
        end else if (cand) begin
          m_wen = 1'b1;
          if (mq.size() > 0) begin
            head = mq.pop_front();
            m_wdata = head[36:5];
            m_widx  = head[4:0];
            if (alu_take) mq.push_back({alu_wbck_data, alu_wbck_rdidx});
          end else begin
            m_wdata = alu_wbck_data;
            m_widx  = alu_wbck_rdidx;
          end
          m_starve = 0;
        end else begin
          m_wen    = 1'b0;
          m_starve = 0;
        end
      end
    end
  end

  // Compare process: DUT against model on every falling edge once reset is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        checkOutput("alu_ready", 32'(alu_wbck_ready), 32'(exp_alu_ready()));
        checkOutput("lsu_ready", 32'(lsu_wbck_ready), 32'(exp_lsu_ready()));
        checkOutput("rf_wen", 32'(rf_wen), 32'(m_wen));
        checkOutput("rf_wdata", rf_wdata, m_wdata);
        checkOutput("rf_wrdidx", 32'(rf_wrdidx), 32'(m_widx));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic av, input logic aen,
                               input logic [31:0] ad, input logic [4:0] ard,
                               input logic lv, input logic [31:0] ld, input logic [4:0] lrd);
    rst            = r;
    alu_wbck_valid = av;
    alu_wbck_en    = aen;
    alu_wbck_data  = ad;
    alu_wbck_rdidx = ard;
    lsu_wbck_valid = lv;
    lsu_wbck_data  = ld;
    lsu_wbck_rdidx = lrd;
    #2;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 0, 0, 32'h0, 5'd0, 0, 32'h0, 5'd0);
  endtask

  logic [31:0] seq_data [3];
  int          ai;
  bit          acc;

  initial begin
    rst = 1'b1;
    alu_wbck_valid = 0; alu_wbck_en = 0; alu_wbck_data = 0; alu_wbck_rdidx = 0;
    lsu_wbck_valid = 0; lsu_wbck_data = 0; lsu_wbck_rdidx = 0;
    stepClock();
    idle(1);
    checkOutput("reset_alu_ready", 32'(alu_wbck_ready), 32'd1);
    checkOutput("reset_lsu_ready", 32'(lsu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("reset_rf_wen", 32'(rf_wen), 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    checkOutput("reset_rf_wrdidx", 32'(rf_wrdidx), 32'd0);

    // Lone ALU beat: written on the next edge.
    applyStimulus(0, 1, 1, 32'h12345678, 5'd5, 0, 32'h0, 5'd0);
    checkOutput("single_alu_ready", 32'(alu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("single_wen", 32'(rf_wen), 32'd1);
    checkOutput("single_wdata", rf_wdata, 32'h12345678);
    checkOutput("single_idx", 32'(rf_wrdidx), 32'd5);
    idle(0);
    stepClock();
    checkOutput("idle_wen", 32'(rf_wen), 32'd0);

    // Simultaneous ALU and LSU: load first, buffered ALU next.
    applyStimulus(0, 1, 1, 32'hA, 5'd3, 1, 32'hB, 5'd4);
    checkOutput("both_alu_ready", 32'(alu_wbck_ready), 32'd1);
    checkOutput("both_lsu_ready", 32'(lsu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("both_first_idx", 32'(rf_wrdidx), 32'd4);
    checkOutput("both_first_data", rf_wdata, 32'hB);
    idle(0);
    stepClock();
    checkOutput("both_second_wen", 32'(rf_wen), 32'd1);
    checkOutput("both_second_idx", 32'(rf_wrdidx), 32'd3);
    checkOutput("both_second_data", rf_wdata, 32'hA);
    idle(0);
    stepClock();

    // Continuous loads against three ALU beats: forced ALU wins every 4th cycle.
    seq_data[0] = 32'd1; seq_data[1] = 32'd2; seq_data[2] = 32'd3;
    ai = 0;
    for (int c = 0; c < 12; c++) begin
      if (ai < 3)
        applyStimulus(0, 1, 1, seq_data[ai], 5'(ai + 1), 1, 32'h100 + 32'(c), 5'(16 + c));
      else
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 1, 32'h100 + 32'(c), 5'(16 + c));
      if (c == 2 || c == 3) checkOutput("full_alu_ready", 32'(alu_wbck_ready), 32'd0);
      if (c == 3 || c == 7 || c == 11) checkOutput("starve_lsu_ready", 32'(lsu_wbck_ready), 32'd0);
      acc = alu_wbck_valid && alu_wbck_ready;
      stepClock();
      if (acc) ai++;
      checkOutput("starve_wen", 32'(rf_wen), 32'd1);
      if (c == 3) begin
        checkOutput("starve_rd1_idx", 32'(rf_wrdidx), 32'd1);
        checkOutput("starve_rd1_data", rf_wdata, 32'd1);
      end else if (c == 7) begin
        checkOutput("starve_rd2_idx", 32'(rf_wrdidx), 32'd2);
        checkOutput("starve_rd2_data", rf_wdata, 32'd2);
      end else if (c == 11) begin
        checkOutput("starve_rd3_idx", 32'(rf_wrdidx), 32'd3);
        checkOutput("starve_rd3_data", rf_wdata, 32'd3);
      end else begin
        checkOutput("starve_lsu_idx", 32'(rf_wrdidx), 32'(16 + c));
      end
    end
    checkOutput("starve_alu_accepted", 32'(ai), 32'd3);
    idle(0);
    stepClock();

    // Discarded ALU beats: handshaken but never written.
    applyStimulus(0, 1, 0, 32'h55, 5'd7, 0, 32'h0, 5'd0);
    checkOutput("discard_en_ready", 32'(alu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("discard_en_wen", 32'(rf_wen), 32'd0);
    applyStimulus(0, 1, 1, 32'h66, 5'd0, 0, 32'h0, 5'd0);
    checkOutput("discard_rd0_ready", 32'(alu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("discard_rd0_wen", 32'(rf_wen), 32'd0);

    // rd=0 load with a queued ALU head: head wins the same cycle.
    applyStimulus(0, 1, 1, 32'h77, 5'd9, 1, 32'h88, 5'd10);
    stepClock();
    checkOutput("lsu0_pre_idx", 32'(rf_wrdidx), 32'd10);
    applyStimulus(0, 0, 0, 32'h0, 5'd0, 1, 32'h99, 5'd0);
    checkOutput("lsu0_ready", 32'(lsu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("lsu0_head_wen", 32'(rf_wen), 32'd1);
    checkOutput("lsu0_head_idx", 32'(rf_wrdidx), 32'd9);
    checkOutput("lsu0_head_data", rf_wdata, 32'h77);
    idle(0);
    stepClock();

    // Reset while the buffer holds two entries: they must vanish.
    applyStimulus(0, 1, 1, 32'hDEAD0001, 5'd12, 1, 32'h11, 5'd11);
    stepClock();
    applyStimulus(0, 1, 1, 32'hDEAD0002, 5'd13, 1, 32'h22, 5'd11);
    stepClock();
    idle(1);
    checkOutput("midrst_alu_ready", 32'(alu_wbck_ready), 32'd1);
    stepClock();
    checkOutput("midrst_wen", 32'(rf_wen), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      checkOutput("postrst_alu_ready", 32'(alu_wbck_ready), 32'd1);
      stepClock();
      checkOutput("postrst_wen", 32'(rf_wen), 32'd0);
      checkOutput("postrst_wdata", rf_wdata, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
